// File: rtl/jtframe_lfbuf_line_pkg.sv
// Shared line-buffer sizing, also used by the DDR frame-buffer controller.
package jtframe_lfbuf_line_pkg;
  localparam int LFBUF_HW = 9;
  localparam int LFBUF_DW = 16;
  localparam logic [LFBUF_DW-1:0] LFBUF_CLR_VAL = '0;
endpackage

// File: rtl/jtframe_lfbuf_bank.sv
// One line bank: single synchronous write port, asynchronous read port.
module jtframe_lfbuf_bank #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/jtframe_lfbuf_line.sv
// Ping-pong game line buffer feeding the DDR controller, plus ping-pong
// scan buffer refilled from DDR and played out on the pixel clock enable.
module jtframe_lfbuf_line
  import jtframe_lfbuf_line_pkg::*;
#(
  parameter int HW = LFBUF_HW,
  parameter int DW = LFBUF_DW,
  parameter logic [DW-1:0] CLR_VAL = LFBUF_CLR_VAL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          lhbl,
  input  logic [HW-1:0] ln_addr,
  input  logic [DW-1:0] ln_data,
  input  logic          ln_we,
  input  logic          line,
  input  logic [HW-1:0] fb_addr,
  input  logic          fb_clr,
  output logic [DW-1:0] fb_din,
  input  logic [HW-1:0] rd_addr,
  input  logic          scr_we,
  input  logic [DW-1:0] fb_dout,
  output logic [DW-1:0] pxl,
  output logic [HW-1:0] hdump
);
  localparam logic [HW-1:0] HMAX = '1;

  logic          disp, lhbl_l;
  logic [DW-1:0] g_rd [2];
  logic [DW-1:0] s_rd [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BID = (b == 1);
    // Game side owns bank 'line'; the clear sweep always owns the other one
    logic          game_side, g_we, s_we;
    logic [HW-1:0] g_addr;
    logic [DW-1:0] g_data;

    assign game_side = (line == BID);
    assign g_we      = ~rst & (game_side ? ln_we : fb_clr);
    assign g_addr    = game_side ? ln_addr : fb_addr;
    assign g_data    = game_side ? ln_data : CLR_VAL;
    assign s_we      = ~rst & scr_we & (disp != BID);

    jtframe_lfbuf_bank #(.AW(HW), .DW(DW)) u_game (
      .clk(clk), .we(g_we), .waddr(g_addr), .wdata(g_data),
      .raddr(fb_addr), .rdata(g_rd[b])
    );

    jtframe_lfbuf_bank #(.AW(HW), .DW(DW)) u_scan (
      .clk(clk), .we(s_we), .waddr(rd_addr), .wdata(fb_dout),
      .raddr(hdump), .rdata(s_rd[b])
    );
  end

  assign fb_din = g_rd[~line];

  always_ff @(posedge clk) begin
    if (rst) begin
      disp   <= 1'b0;
      hdump  <= '0;
      pxl    <= '0;
      lhbl_l <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_l <= lhbl;
      pxl    <= lhbl ? s_rd[disp] : '0;
      // Line start wins over the increment; the counter parks at the last pixel
      if (lhbl && !lhbl_l) begin
        disp  <= ~disp;
        hdump <= '0;
      end else if (lhbl && hdump != HMAX) begin
        hdump <= hdump + 1'b1;
      end
    end
  end
endmodule
